hcordic_stage: RTL and testbench
================================

HCORDIC_STAGE -- requirements
Module: hcordic_stage

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
  DWIDTH, 32, two's-complement width of the x, y and z data paths.
  FRA_WIDTH, 16, number of fractional bits in every data word.
  SHIFT, 1, micro-rotation index i, giving a shift of 2^-i; legal range is 1..DWIDTH-2.
  REPEAT, 0, when 1 the stage performs the same micro-rotation twice (used for i = 4, 13, 40).
  ATANH, 0, DWIDTH-bit constant equal to atanh(2^-SHIFT) in the FRA_WIDTH fixed-point format.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
  clk, input, 1, sole clock; all state changes on the rising edge.
  rst_n, input, 1, reset; asynchronous, active-low.
  in_valid, input, 1, an input transaction is offered.
  in_ready, output, 1, the stage can accept an input transaction.
  in_mode, input, 1, operating mode: 0 = rotation, 1 = vectoring.
  in_x, input, DWIDTH, x operand.
  in_y, input, DWIDTH, y operand.
  in_z, input, DWIDTH, z operand.
  out_valid, output, 1, a result is presented.
  out_ready, input, 1, the downstream consumer takes the result.
  out_mode, output, 1, in_mode of the transaction, passed through unchanged.
  out_x, output, DWIDTH, x result.
  out_y, output, DWIDTH, y result.
  out_z, output, DWIDTH, z result.

Function
REQ-003 A transaction SHALL be accepted on a clock edge where in_valid and in_ready are both 1; a result SHALL be transferred on a clock edge where out_valid and out_ready are both 1.
REQ-004 Each micro-rotation SHALL compute x' = x + d*(y>>>SHIFT), y' = y + d*(x>>>SHIFT), z' = z - d*ATANH, where >>> is an arithmetic right shift.
REQ-005 The rotation direction d SHALL be selected as follows:
  Rotation mode: d = +1 when z >= 0, otherwise d = -1.
  Vectoring mode: d = +1 when y < 0, otherwise d = -1.
  d SHALL be evaluated fresh from the current operands before every micro-rotation, including the repeat.
REQ-006 Additions SHALL wrap modulo 2^DWIDTH; the exception is x and y when HCORDIC_SAT_EN is defined (see REQ-015). The z path SHALL always wrap.
REQ-007 The state machine SHALL have three states:
  EMPTY: no data held.
  BUSY: the first micro-rotation is done and the repeat is pending; this state exists only when REPEAT = 1.
  FULL: a result is held on the outputs.
REQ-008 State transitions SHALL be:
  From EMPTY on accept: go to FULL when REPEAT = 0, or to BUSY when REPEAT = 1.
  From BUSY: go to FULL unconditionally after one cycle.
  From FULL on transfer without a new accept: go to EMPTY.
  From FULL on transfer with a simultaneous accept: go to FULL when REPEAT = 0, or to BUSY when REPEAT = 1.
REQ-009 The handshake outputs SHALL be decoded as follows:
  in_ready = (state == EMPTY) || (state == FULL && out_ready).
  out_valid = (state == FULL).
  in_ready SHALL be 0 in BUSY.
REQ-010 Latency from accept to out_valid SHALL be 1 cycle when REPEAT = 0 and 2 cycles when REPEAT = 1.
REQ-011 Throughput SHALL be 1 transaction per cycle when REPEAT = 0 and 1 transaction per 2 cycles when REPEAT = 1.
REQ-012 While out_valid = 1 and out_ready = 0, out_x, out_y, out_z and out_mode SHALL hold stable, and no input SHALL be accepted.
REQ-013 in_mode SHALL be captured at accept and SHALL apply to both micro-rotations of the transaction.

Reset
REQ-014 When rst_n = 0, the block SHALL asynchronously force:
  state to EMPTY;
  out_valid = 0 and in_ready = 0;
  out_x, out_y, out_z and out_mode to 0.
  A transaction in flight (BUSY or FULL) SHALL be discarded.
  in_ready SHALL become 1 on the first clock edge after rst_n is released.

Configuration
REQ-015 With the macro HCORDIC_SAT_EN defined, the x' and y' results SHALL saturate on overflow: to 2^(DWIDTH-1)-1 on positive overflow and to -2^(DWIDTH-1) on negative overflow. Without HCORDIC_SAT_EN, x' and y' SHALL wrap.

Verification
All scenarios use DWIDTH = 16 and FRA_WIDTH = 12 unless stated otherwise.
REQ-016 Rotation, single step: SHIFT = 1, ATANH = 2250, in_mode = 0, x = 4096, y = 0, z = 1000 -> one cycle later, out = (4096, 2048, -1250).
REQ-017 Vectoring, single step: SHIFT = 1, ATANH = 2250, in_mode = 1, x = 4096, y = 1024, z = 0 -> out = (3584, -1024, 2250).
REQ-018 Repeat: SHIFT = 4, REPEAT = 1, ATANH = 256, in_mode = 0, x = 4096, y = 0, z = 1000 -> out_valid 2 cycles after accept, out = (4112, 512, 488); in_ready = 0 during the BUSY cycle.
REQ-019 Backpressure: SHIFT = 1, hold out_ready = 0 for 5 cycles with in_valid = 1 -> outputs stable and in_ready = 0 throughout. Then assert out_ready = 1 with a new input -> transfer and accept happen on the same edge, and the stage stays FULL.
REQ-020 Overflow: SHIFT = 1, in_mode = 0, x = 32767, y = 32767, z = 0 -> out_x = 32767 with HCORDIC_SAT_EN defined, and out_x = -16386 without it.
REQ-021 Reset mid-operation: REPEAT = 1, assert rst_n = 0 while in BUSY -> out_valid = 0 and all outputs = 0 immediately, with no clock edge required. After release, the next accepted transaction produces correct results.

Source files
------------

// File: rtl/hcordic_stage.sv
// -----------------------------------------------------------------------------
// hcordic_stage
//
// One hyperbolic CORDIC micro-rotation stage with a valid/ready handshake on
// both sides. Each accepted transaction is rotated by +/-atanh(2^-SHIFT); with
// REPEAT = 1 the same micro-rotation is applied a second time in the following
// cycle (the classic i = 4, 13, 40 repeats needed for hyperbolic convergence).
//
// Parameters
//   DWIDTH    two's-complement width of x, y, z
//   FRA_WIDTH fractional bits of every word (format only, no arithmetic effect)
//   SHIFT     micro-rotation index i (shift of 2^-i), 1..DWIDTH-2
//   REPEAT    1 = perform the micro-rotation twice
//   ATANH     atanh(2^-SHIFT) in the data fixed-point format
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   in_valid/in_ready         input handshake
//   in_mode                   0 = rotation (drive z to 0), 1 = vectoring (drive y to 0)
//   in_x, in_y, in_z          operands
//   out_valid/out_ready       output handshake
//   out_mode, out_x/y/z       registered results
//
// Configuration macro
//   HCORDIC_SAT_EN  when defined, x and y saturate on overflow instead of wrapping
//                   (z always wraps).
// -----------------------------------------------------------------------------
module hcordic_stage #(
    parameter int DWIDTH    = 32,
    parameter int FRA_WIDTH = 16,
    parameter int SHIFT     = 1,
    parameter int REPEAT    = 0,
    parameter logic signed [DWIDTH-1:0] ATANH = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic signed [DWIDTH-1:0] in_x,
    input  logic signed [DWIDTH-1:0] in_y,
    input  logic signed [DWIDTH-1:0] in_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_mode,
    output logic signed [DWIDTH-1:0] out_x,
    output logic signed [DWIDTH-1:0] out_y,
    output logic signed [DWIDTH-1:0] out_z
);

    // Elaboration-time sanity checks on the configuration.
    if (SHIFT < 1 || SHIFT > DWIDTH - 2) begin : g_bad_shift
        $error("hcordic_stage: SHIFT out of range 1..DWIDTH-2");
    end
    if (FRA_WIDTH < 0 || FRA_WIDTH >= DWIDTH) begin : g_bad_fra
        $error("hcordic_stage: FRA_WIDTH must lie in 0..DWIDTH-1");
    end

`ifdef HCORDIC_SAT_EN
    localparam logic signed [DWIDTH-1:0] XY_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH-1:0] XY_MIN = {1'b1, {(DWIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic                       init_q;
    logic                       mode_q, mode_d;
    logic signed [DWIDTH-1:0]   x_q, y_q, z_q;
    logic signed [DWIDTH-1:0]   x_d, y_d, z_d;

    logic                       accept, xfer;
    logic                       op_mode, d_neg;
    logic signed [DWIDTH-1:0]   op_x, op_y, op_z;
    logic signed [DWIDTH-1:0]   sh_x, sh_y;
    logic signed [DWIDTH-1:0]   rot_x, rot_y, rot_z;

    // x/y add or subtract, one guard bit to detect overflow for saturation.
    function automatic logic signed [DWIDTH-1:0] add_xy(
        input logic signed [DWIDTH-1:0] a,
        input logic signed [DWIDTH-1:0] b,
        input logic                     sub
    );
        logic signed [DWIDTH:0] s;
        if (sub) s = {a[DWIDTH-1], a} - {b[DWIDTH-1], b};
        else     s = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
`ifdef HCORDIC_SAT_EN
        if (s[DWIDTH] != s[DWIDTH-1]) begin
            return s[DWIDTH] ? XY_MIN : XY_MAX;
        end
`endif
        return s[DWIDTH-1:0];
    endfunction

    // Handshake decode. init_q keeps in_ready low until the first clock edge
    // after reset release.
    assign in_ready  = init_q && ((state_q == S_EMPTY) ||
                                  (state_q == S_FULL && out_ready));
    assign out_valid = (state_q == S_FULL);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    assign out_mode  = mode_q;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_z     = z_q;

    // Operand select: the repeat step works on the held intermediate result,
    // otherwise the rotation is applied to the incoming operands.
    always_comb begin
        if (state_q == S_BUSY) begin
            op_x    = x_q;
            op_y    = y_q;
            op_z    = z_q;
            op_mode = mode_q;
        end else begin
            op_x    = in_x;
            op_y    = in_y;
            op_z    = in_z;
            op_mode = in_mode;
        end

        // d = -1 in rotation when z < 0, in vectoring when y >= 0.
        d_neg = op_mode ? ~op_y[DWIDTH-1] : op_z[DWIDTH-1];

        sh_x  = op_x >>> SHIFT;
        sh_y  = op_y >>> SHIFT;
        rot_x = add_xy(op_x, sh_y, d_neg);
        rot_y = add_xy(op_y, sh_x, d_neg);
        rot_z = d_neg ? (op_z + ATANH) : (op_z - ATANH);
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;

        case (state_q)
            S_EMPTY, S_FULL: begin
                if (accept) begin
                    state_d = (REPEAT != 0) ? S_BUSY : S_FULL;
                    mode_d  = in_mode;
                    x_d     = rot_x;
                    y_d     = rot_y;
                    z_d     = rot_z;
                end else if (xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_BUSY: begin
                state_d = S_FULL;
                x_d     = rot_x;
                y_d     = rot_y;
                z_d     = rot_z;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            init_q  <= 1'b0;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

endmodule

// File: tb/tb_hcordic_stage.sv
// -----------------------------------------------------------------------------
// tb_hcordic_stage
//
// Two stages are instantiated side by side (DWIDTH 16, FRA_WIDTH 12):
//   u0: SHIFT 1, REPEAT 0, ATANH 2250
//   u1: SHIFT 4, REPEAT 1, ATANH 256
// Directed cases cover the documented example transactions, backpressure,
// overflow and reset in flight; a randomized phase then checks results
// against an integer reference model through a scoreboard per instance.
// -----------------------------------------------------------------------------
module tb_hcordic_stage;

    localparam int DW = 16;

    typedef struct {
        int m;
        int x;
        int y;
        int z;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]           in_valid, in_ready, in_mode;
    logic [1:0]           out_valid, out_ready, out_mode;
    logic signed [DW-1:0] in_x [2];
    logic signed [DW-1:0] in_y [2];
    logic signed [DW-1:0] in_z [2];
    logic signed [DW-1:0] out_x [2];
    logic signed [DW-1:0] out_y [2];
    logic signed [DW-1:0] out_z [2];

    int checks = 0;
    int errors = 0;

    txn_t sb0[$];
    txn_t sb1[$];

    hcordic_stage #(
        .DWIDTH(DW), .FRA_WIDTH(12), .SHIFT(1), .REPEAT(0), .ATANH(16'sd2250)
    ) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]),
        .in_x(in_x[0]), .in_y(in_y[0]), .in_z(in_z[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_mode(out_mode[0]),
        .out_x(out_x[0]), .out_y(out_y[0]), .out_z(out_z[0])
    );

    hcordic_stage #(
        .DWIDTH(DW), .FRA_WIDTH(12), .SHIFT(4), .REPEAT(1), .ATANH(16'sd256)
    ) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]),
        .in_x(in_x[1]), .in_y(in_y[1]), .in_z(in_z[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_mode(out_mode[1]),
        .out_x(out_x[1]), .out_y(out_y[1]), .out_z(out_z[1])
    );

    task automatic chk(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int wrap16(input int v);
        int w;
        w = v & 32'h0000FFFF;
        if (w > 32767) w = w - 65536;
        return w;
    endfunction

    function automatic int fit_xy(input int v);
`ifdef HCORDIC_SAT_EN
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        return wrap16(v);
`endif
    endfunction

    function automatic txn_t model(input int k, input txn_t t);
        txn_t r;
        int   sh, at, reps, d, nx, ny;
        sh   = (k == 0) ? 1 : 4;
        at   = (k == 0) ? 2250 : 256;
        reps = (k == 0) ? 1 : 2;
        r    = t;
        for (int i = 0; i < reps; i++) begin
            if (r.m != 0) d = (r.y < 0) ? 1 : -1;
            else          d = (r.z >= 0) ? 1 : -1;
            nx  = fit_xy(r.x + d * (r.y >>> sh));
            ny  = fit_xy(r.y + d * (r.x >>> sh));
            r.z = wrap16(r.z - d * at);
            r.x = nx;
            r.y = ny;
        end
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic drive(input int k, input logic v, input txn_t t, input logic ordy);
        in_valid[k]  = v;
        in_mode[k]   = t.m[0];
        in_x[k]      = t.x[DW-1:0];
        in_y[k]      = t.y[DW-1:0];
        in_z[k]      = t.z[DW-1:0];
        out_ready[k] = ordy;
    endtask

    task automatic chk_out(input string tag, input int k, input txn_t e);
        chk({tag, "_mode"}, out_mode[k], e.m);
        chk({tag, "_x"}, out_x[k], e.x);
        chk({tag, "_y"}, out_y[k], e.y);
        chk({tag, "_z"}, out_z[k], e.z);
    endtask

    // One transaction through instance k with out_ready held high.
    task automatic run_one(input string tag, input int k, input txn_t t, input txn_t e);
        @(negedge clk);
        drive(k, 1'b1, t, 1'b1);
        #1 chk({tag, "_inrdy"}, in_ready[k], 1);
        @(negedge clk);
        in_valid[k] = 1'b0;
        #1;
        if (k == 1) begin
            chk({tag, "_busy_ovld"}, out_valid[k], 0);
            chk({tag, "_busy_irdy"}, in_ready[k], 0);
            @(negedge clk);
            #1;
        end
        chk({tag, "_ovld"}, out_valid[k], 1);
        chk_out(tag, k, e);
    endtask

    task automatic sb_push(input int k, input txn_t t);
        if (k == 0) sb0.push_back(t);
        else        sb1.push_back(t);
    endtask

    task automatic sb_check(input int k);
        txn_t e;
        int   n;
        n = (k == 0) ? sb0.size() : sb1.size();
        if (n == 0) begin
            chk("rnd_unexpected_out", out_valid[k], 0);
        end else begin
            e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
            chk_out("rnd", k, e);
        end
    endtask

    task automatic sample_cycle();
        txn_t t;
        for (int k = 0; k < 2; k++) begin
            if (out_valid[k] && !out_ready[k])
                chk("stall_no_accept", in_ready[k], 0);
            if (out_valid[k] && out_ready[k])
                sb_check(k);
            if (in_valid[k] && in_ready[k]) begin
                t.m = int'(in_mode[k]);
                t.x = int'(in_x[k]);
                t.y = int'(in_y[k]);
                t.z = int'(in_z[k]);
                sb_push(k, model(k, t));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t, e, a, b;
        txn_t z0;
        z0 = '{0, 0, 0, 0};
        rst_n = 1'b0;
        drive(0, 1'b0, z0, 1'b0);
        drive(1, 1'b0, z0, 1'b0);

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ovld", out_valid[k], 0);
            chk("rst_irdy", in_ready[k], 0);
            chk_out("rst", k, z0);
        end
        rst_n = 1'b1;
        #1 chk("rel_irdy_before_edge", in_ready[0], 0);
        @(posedge clk);
        #1 chk("rel_irdy_after_edge0", in_ready[0], 1);
        chk("rel_irdy_after_edge1", in_ready[1], 1);

        // ---------------- documented single-step examples ----------------
        run_one("rot1", 0, '{0, 4096, 0, 1000}, '{0, 4096, 2048, -1250});
        run_one("vec1", 0, '{1, 4096, 1024, 0}, '{1, 3584, -1024, 2250});
        run_one("rep4", 1, '{0, 4096, 0, 1000}, '{0, 4112, 512, 488});

        // ---------------- overflow ----------------
`ifdef HCORDIC_SAT_EN
        e = '{0, 32767, 32767, -2250};
`else
        e = '{0, -16386, -16386, -2250};
`endif
        run_one("ovf", 0, '{0, 32767, 32767, 0}, e);

        // ---------------- backpressure ----------------
        a = '{0, 4096, 0, 1000};
        b = '{1, 4096, 1024, 0};
        @(negedge clk);
        drive(0, 1'b1, a, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, b, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_irdy", in_ready[0], 0);
            chk("bp_ovld", out_valid[0], 1);
            chk_out("bp_hold", 0, '{0, 4096, 2048, -1250});
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        #1 chk("bp_release_irdy", in_ready[0], 1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1 chk("bp_still_full", out_valid[0], 1);
        chk_out("bp_new", 0, '{1, 3584, -1024, 2250});
        @(negedge clk);
        #1 chk("bp_drained", out_valid[0], 0);

        // ---------------- reset while BUSY ----------------
        @(negedge clk);
        drive(1, 1'b1, a, 1'b1);
        @(negedge clk);
        in_valid[1] = 1'b0;
        #1 chk("rstmid_in_busy", in_ready[1], 0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_ovld", out_valid[1], 0);
        chk("rstmid_irdy", in_ready[1], 0);
        chk_out("rstmid", 1, z0);
        @(negedge clk);
        #1 chk("rstmid_held_ovld", out_valid[1], 0);
        rst_n = 1'b1;
        run_one("post_rst", 1, '{1, 4096, 1024, 0}, model(1, '{1, 4096, 1024, 0}));
        @(negedge clk);

        // ---------------- randomized traffic ----------------
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                t.m = int'($urandom_range(0, 1));
                t.x = wrap16(int'($urandom));
                t.y = wrap16(int'($urandom));
                t.z = wrap16(int'($urandom));
                drive(k, $urandom_range(0, 3) != 0, t, $urandom_range(0, 3) != 0);
            end
            #1 sample_cycle();
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            drive(0, 1'b0, z0, 1'b1);
            drive(1, 1'b0, z0, 1'b1);
            #1 sample_cycle();
        end
        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
